// File: rtl/alu_op_issue_pkg.sv
// alu_pkg: shared types and constants for the ID->EX ALU issue stage.
//   alu_op_e  : 4-bit ALU operation code consumed by EX
//   OPC_*     : RV32I major opcodes recognised by the decoder
//   issue_t   : one decoded ALU command (what the stage registers)
//   state_e   : occupancy of the 2-entry skid buffer
//   sext12    : sign-extend a 12-bit immediate to XLEN
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_SLT = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_GE  = 4'b1000
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_e                  Op;
    logic signed [XLEN-1:0]   Op1;
    logic signed [XLEN-1:0]   Op2;
    logic [REG_AW-1:0]        rd;
    logic                     is_branch;
    logic [2:0]               br_funct3;
    logic                     illegal;
  } issue_t;

  // Encoding chosen so out_valid = state[0] and in_ready = !state[1]
  // come straight off the state flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_e;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// Handshake bundles around the issue stage.
//   alu_id_if  : ID -> issue. master (ID) drives in_valid/instr/rs1_data/rs2_data,
//                slave (issue stage) drives in_ready.
//   alu_cmd_if : issue -> EX. master (issue stage) drives out_valid and the
//                command fields, slave (EX) drives out_ready.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the
// sender keeps valid and payload stable until that edge, and ready never
// depends combinationally on valid.
interface alu_id_if #(parameter int XLEN = alu_pkg::XLEN);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  modport master (output in_valid, instr, rs1_data, rs2_data, input in_ready);
  modport slave  (input in_valid, instr, rs1_data, rs2_data, output in_ready);
endinterface

interface alu_cmd_if #(parameter int XLEN = alu_pkg::XLEN, parameter int REG_AW = alu_pkg::REG_AW);
  import alu_pkg::*;
  logic                   out_valid;
  logic                   out_ready;
  alu_op_e                Op;
  logic signed [XLEN-1:0] Op1;
  logic signed [XLEN-1:0] Op2;
  logic [REG_AW-1:0]      rd;
  logic                   is_branch;
  logic [2:0]             br_funct3;
  logic                   illegal;

  modport master (output out_valid, Op, Op1, Op2, rd, is_branch, br_funct3, illegal,
                  input out_ready);
  modport slave  (input out_valid, Op, Op1, Op2, rd, is_branch, br_funct3, illegal,
                  output out_ready);
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I -> ALU command decoder.
//   i_instr    : instruction word
//   i_rs1_data : rs1 value, i_rs2_data : rs2 value
//   o_iss      : decoded command; unsupported encodings give illegal=1 with
//                Op=ADD and zero operands/rd so EX computes nothing harmful.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output issue_t          o_iss
);

  typedef enum logic [1:0] {SRC_RS2, SRC_IMM_I, SRC_SHAMT, SRC_IMM_S} src2_e;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_ok;
  logic       w_rd_en;
  logic       w_br;
  alu_op_e    w_op;
  src2_e      w_src2;
  logic       w_unused_rs1_idx;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  // rs1 index is already resolved into i_rs1_data upstream.
  assign w_unused_rs1_idx = ^i_instr[19:15];

  always_comb begin
    w_ok    = 1'b0;
    w_rd_en = 1'b0;
    w_br    = 1'b0;
    w_op    = OP_ADD;
    w_src2  = SRC_RS2;
    case (w_opcode)
      OPC_OP: begin
        w_rd_en = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_ok = 1'b1;
          case (w_f3)
            3'b000:  w_op = OP_ADD;
            3'b010:  w_op = OP_SLT;
            3'b111:  w_op = OP_AND;
            3'b110:  w_op = OP_OR;
            3'b100:  w_op = OP_XOR;
            3'b001:  w_op = OP_SLL;
            3'b101:  w_op = OP_SRL;
            default: w_ok = 1'b0;      // SLTU
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_ok = 1'b1;
          w_op = OP_SUB;
        end
      end
      OPC_OP_IMM: begin
        w_rd_en = 1'b1;
        w_src2  = SRC_IMM_I;
        w_ok    = 1'b1;
        case (w_f3)
          3'b000:  w_op = OP_ADD;
          3'b010:  w_op = OP_SLT;
          3'b111:  w_op = OP_AND;
          3'b110:  w_op = OP_OR;
          3'b100:  w_op = OP_XOR;
          3'b001: begin
            w_op   = OP_SLL;
            w_src2 = SRC_SHAMT;
            w_ok   = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_op   = OP_SRL;
            w_src2 = SRC_SHAMT;
            w_ok   = (w_f7 == 7'b0000000);  // SRAI rejected
          end
          default: w_ok = 1'b0;        // SLTIU
        endcase
      end
      OPC_LOAD: begin
        w_rd_en = 1'b1;
        w_src2  = SRC_IMM_I;
        w_ok    = (w_f3 == 3'b010);
      end
      OPC_STORE: begin
        w_src2 = SRC_IMM_S;
        w_ok   = (w_f3 == 3'b010);
      end
      OPC_BRANCH: begin
        w_br = 1'b1;
        w_ok = 1'b1;
        case (w_f3)
          3'b000, 3'b001: w_op = OP_SUB;  // EX tests Zero
          3'b100:         w_op = OP_SLT;
          3'b101:         w_op = OP_GE;
          default:        w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_iss         = '0;
    o_iss.Op      = OP_ADD;
    o_iss.illegal = 1'b1;
    if (w_ok) begin
      o_iss.illegal   = 1'b0;
      o_iss.Op        = w_op;
      o_iss.Op1       = i_rs1_data;
      o_iss.is_branch = w_br;
      o_iss.br_funct3 = w_br ? w_f3 : 3'b000;
      o_iss.rd        = w_rd_en ? i_instr[11:7] : '0;
      case (w_src2)
        SRC_IMM_I: o_iss.Op2 = sext12(i_instr[31:20]);
        SRC_SHAMT: o_iss.Op2 = {{(XLEN-5){1'b0}}, i_instr[24:20]};
        SRC_IMM_S: o_iss.Op2 = sext12({i_instr[31:25], i_instr[11:7]});
        default:   o_iss.Op2 = i_rs2_data;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: ID->EX issue stage with a 2-entry skid buffer.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : drops M, S and any same-cycle input beat at the next edge
//   id        : alu_id_if.slave  (in_valid/in_ready, instr, rs1_data, rs2_data)
//   cmd       : alu_cmd_if.master (out_valid/out_ready, Op, Op1, Op2, rd,
//               is_branch, br_funct3, illegal)
//   dbg_state : skid-buffer occupancy (EMPTY / ONE / TWO)
// M drives the outputs; S catches the one beat accepted while M is stalled,
// so in_ready is a flop and never sees out_ready combinationally.
module alu_op_issue
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  alu_id_if.slave    id,
  alu_cmd_if.master  cmd,
  output state_e     dbg_state
);

  state_e r_state;
  state_e w_state_nxt;
  issue_t r_m;
  issue_t r_s;
  issue_t w_dec;
  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_load_m_in;
  logic   w_load_m_s;
  logic   w_load_s;

  alu_op_decode u_decode (
    .i_instr    (id.instr),
    .i_rs1_data (id.rs1_data),
    .i_rs2_data (id.rs2_data),
    .o_iss      (w_dec)
  );

  assign id.in_ready   = ~r_state[1];
  assign cmd.out_valid = r_state[0];
  assign w_in_fire     = id.in_valid & ~r_state[1];
  assign w_out_fire    = r_state[0] & cmd.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s    = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_m_in = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_in_fire, w_out_fire})
            2'b11:   w_load_m_in = 1'b1;
            2'b10: begin
              w_load_s    = 1'b1;
              w_state_nxt = ST_TWO;
            end
            2'b01:   w_state_nxt = ST_EMPTY;
            default: w_state_nxt = ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_load_m_s  = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_load_m_in)     r_m <= w_dec;
      else if (w_load_m_s) r_m <= r_s;
      if (w_load_s)        r_s <= w_dec;
    end
  end

  assign cmd.Op        = r_m.Op;
  assign cmd.Op1       = r_m.Op1;
  assign cmd.Op2       = r_m.Op2;
  assign cmd.rd        = r_m.rd;
  assign cmd.is_branch = r_m.is_branch;
  assign cmd.br_funct3 = r_m.br_funct3;
  assign cmd.illegal   = r_m.illegal;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;
  import alu_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_ADDI = 32'hFFF08293;  // addi x5,x1,-1
  localparam logic [31:0] I_SLLI = 32'h00409293;  // slli x5,x1,4
  localparam logic [31:0] I_BGE  = 32'h0020D063;  // bge  x1,x2,0
  localparam logic [31:0] I_SW   = 32'hFE20AE23;  // sw   x2,-4(x1)
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;  // sra  x3,x1,x2

  // clock / reset
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   flush = 1'b0;
  state_e dbg_state;
  always #5 clk = ~clk;

  alu_id_if  id_bus ();
  alu_cmd_if cmd_bus ();

  alu_op_issue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .id        (id_bus),
    .cmd       (cmd_bus),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_op1;

  // {out_valid, Op, Op1, Op2, rd, is_branch, br_funct3, illegal}
  function automatic logic [78:0] obs();
    return {cmd_bus.out_valid, cmd_bus.Op, cmd_bus.Op1, cmd_bus.Op2, cmd_bus.rd,
            cmd_bus.is_branch, cmd_bus.br_funct3, cmd_bus.illegal};
  endfunction

  function automatic logic [78:0] mk(input logic v, input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] rd, input logic br,
                                     input logic [2:0] f3, input logic ill);
    return {v, op, a, b, rd, br, f3, ill};
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
    id_bus.in_valid = v;
    id_bus.instr    = ins;
    id_bus.rs1_data = a;
    id_bus.rs2_data = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cmd_bus.out_ready = 1'b1;
    #1;
    checks++;
    if (obs() !== 79'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs(), 79'h0);
    end
    checks++;
    if (id_bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", id_bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [78:0] e;
    @(negedge clk);
    drive(1'b1, I_ADD, 32'd70, 32'd50);
    step();
    e = mk(1'b1, 4'b0000, 32'd70, 32'd50, 5'd3, 1'b0, 3'd0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL add: got %h want %h", obs(), e);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if (cmd_bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: out_valid got %b want 0", cmd_bus.out_valid);
    end
  endtask

  task automatic test_imm();
    logic [78:0] e;
    @(negedge clk);
    drive(1'b1, I_ADDI, 32'd10, 32'd99);
    step();
    e = mk(1'b1, 4'b0000, 32'd10, 32'hFFFFFFFF, 5'd5, 1'b0, 3'd0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL addi: got %h want %h", obs(), e);
    end
    @(negedge clk);
    drive(1'b1, I_SLLI, 32'd10, 32'd99);
    step();
    e = mk(1'b1, 4'b0110, 32'd10, 32'd4, 5'd5, 1'b0, 3'd0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL slli: got %h want %h", obs(), e);
    end
    @(negedge clk);
    drive(1'b1, I_SW, 32'h1000, 32'hDEAD);
    step();
    e = mk(1'b1, 4'b0000, 32'h1000, 32'hFFFFFFFC, 5'd0, 1'b0, 3'd0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL sw: got %h want %h", obs(), e);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_branch();
    logic [78:0] e;
    @(negedge clk);
    drive(1'b1, I_BGE, 32'd80, 32'd70);
    step();
    e = mk(1'b1, 4'b1000, 32'd80, 32'd70, 5'd0, 1'b1, 3'b101, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL bge: got %h want %h", obs(), e);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_illegal();
    logic [78:0] e;
    @(negedge clk);
    drive(1'b1, I_SRA, 32'd5, 32'd6);
    step();
    e = mk(1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL sra_illegal: got %h want %h", obs(), e);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_backpressure();
    logic [78:0] ea;
    logic [78:0] eb;
    ea = mk(1'b1, 4'b0000, 32'd1, 32'd2, 5'd3, 1'b0, 3'd0, 1'b0);
    eb = mk(1'b1, 4'b0001, 32'd9, 32'd4, 5'd3, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    cmd_bus.out_ready = 1'b0;
    drive(1'b1, I_ADD, 32'd1, 32'd2);
    step();
    @(negedge clk);
    drive(1'b1, I_SUB, 32'd9, 32'd4);
    step();
    checks++;
    if (obs() !== ea || id_bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_capture: got %h ready=%b want %h ready=0", obs(), id_bus.in_ready, ea);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    checks++;
    if (obs() !== ea) begin
      errors++;
      $display("FAIL bp_hold: got %h want %h", obs(), ea);
    end
    @(negedge clk);
    cmd_bus.out_ready = 1'b1;
    step();
    checks++;
    if (obs() !== eb || id_bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %h ready=%b want %h ready=1", obs(), id_bus.in_ready, eb);
    end
    step();
    checks++;
    if (cmd_bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: out_valid got %b want 0", cmd_bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cmd_bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, I_ADD, 32'd100 + i, i);
      exp_q.push_back(32'd100 + i);
      step();
      exp_op1 = exp_q.pop_front();
      checks++;
      if (cmd_bus.out_valid !== 1'b1 || cmd_bus.Op1 !== exp_op1 || id_bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b op1=%h ready=%b want v=1 op1=%h ready=1",
                 i, cmd_bus.out_valid, cmd_bus.Op1, id_bus.in_ready, exp_op1);
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if (cmd_bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid got %b want 0", cmd_bus.out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    cmd_bus.out_ready = 1'b0;
    drive(1'b1, I_ADD, 32'd11, 32'd0);
    step();
    @(negedge clk);
    drive(1'b1, I_ADD, 32'd22, 32'd0);
    step();
    @(negedge clk);
    drive(1'b1, I_ADD, 32'd33, 32'd0);
    flush = 1'b1;
    step();
    checks++;
    if (cmd_bus.out_valid !== 1'b0 || id_bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: got v=%b ready=%b want v=0 ready=1", cmd_bus.out_valid, id_bus.in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    cmd_bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cmd_bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_gone_%0d: out_valid got %b want 0 (op1=%h)", i, cmd_bus.out_valid, cmd_bus.Op1);
      end
    end
    @(negedge clk);
    drive(1'b1, I_ADD, 32'd44, 32'd0);
    step();
    checks++;
    if (cmd_bus.out_valid !== 1'b1 || cmd_bus.Op1 !== 32'sd44) begin
      errors++;
      $display("FAIL flush_resume: got v=%b op1=%h want v=1 op1=0000002c", cmd_bus.out_valid, cmd_bus.Op1);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    cmd_bus.out_ready = 1'b0;
    drive(1'b1, I_ADD, 32'd66, 32'd1);
    step();
    @(negedge clk);
    drive(1'b1, I_BGE, 32'd77, 32'd1);
    step();
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 79'h0 || id_bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got %h ready=%b want 0 ready=1", obs(), id_bus.in_ready);
    end
    cmd_bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, I_ADD, 32'd55, 32'd5);
    step();
    checks++;
    if (obs() !== mk(1'b1, 4'b0000, 32'd55, 32'd5, 5'd3, 1'b0, 3'd0, 1'b0)) begin
      errors++;
      $display("FAIL rst_first_accept: got %h want op1=55 op2=5 rd=3", obs());
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    checks++;
    if (cmd_bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_stale: out_valid got %b want 0 (op1=%h)", cmd_bus.out_valid, cmd_bus.Op1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_branch();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- ID→EX issue stage: decodes an RV32I instruction word plus already-read register operands into the ALU command triple (Op, Op1, Op2) and registers it for the EX stage.
- Producer side of the ALU command interface; the ALU consumes exactly the Op/Op1/Op2 this block drives.
- Valid/ready on both sides, 2-entry skid buffer for full throughput under backpressure, synchronous flush for branch mispredicts.

Parameters:
- XLEN, 32, operand width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all held and incoming entries this cycle
- in_valid  in  1  ID offers an instruction
- in_ready  out  1  stage can accept (registered)
- instr  in  32  instruction word
- rs1_data  in  XLEN  register-file value of rs1
- rs2_data  in  XLEN  register-file value of rs2
- out_valid  out  1  command valid to EX
- out_ready  in  1  EX accepts
- Op  out  4  ALU operation code
- Op1  out  XLEN signed  ALU operand 1
- Op2  out  XLEN signed  ALU operand 2
- rd  out  REG_AW  destination register (0 for store/branch)
- is_branch  out  1  conditional branch; EX uses Zero/sol
- br_funct3  out  3  branch funct3 passthrough
- illegal  out  1  unsupported encoding

Behaviour:
- Op codes: ADD=0000, SUB=0001, SLT=0010, AND=0011, OR=0100, XOR=0101, SLL=0110, SRL=0111, GE=1000.
- Decode, opcode 0110011 (R): funct7=0000000 with funct3 000/010/111/110/100/001/101 → ADD/SLT/AND/OR/XOR/SLL/SRL; funct7=0100000 with funct3 000 → SUB. Op1=rs1_data, Op2=rs2_data.
- Decode, 0010011 (I): funct3 000/010/111/110/100 → ADD/SLT/AND/OR/XOR with Op2=sext(instr[31:20]). funct3 001 (funct7=0) → SLL, funct3 101 (funct7=0) → SRL, both with Op2=zext(instr[24:20]).
- Decode, 0000011 funct3 010 (LW): ADD, Op2=sext I-imm.
- Decode, 0100011 funct3 010 (SW): ADD, Op2=sext {instr[31:25],instr[11:7]}, rd=0.
- Decode, 1100011 (branch): funct3 000/001 → SUB; 100 → SLT; 101 → GE. Op1=rs1, Op2=rs2, is_branch=1, rd=0.
- Any other encoding (SRA, SLTU, BLTU, LUI, ...): illegal=1, Op=ADD, Op1=Op2=0, rd=0, is_branch=0; still flows through the handshake.
- Storage: main register M (drives outputs) and skid register S.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when M is empty or draining.
- Input accepted while M holds data and the output does not transfer: the entry goes into S; in_ready drops the next cycle.
- Output transfer while S is full: S moves to M; in_ready rises the next cycle.
- Simultaneous input and output transfer with S empty: M loads the new entry; throughput is 1/cycle.
- in_ready = !S_full, taken from a flop; no combinational path from out_ready.
- M/S order is strictly FIFO; no reordering.
- Output fields hold stable while out_valid && !out_ready.
- flush=1: M and S are invalidated at the next edge and any same-cycle input beat is dropped. Next cycle: out_valid=0, in_ready=1. Flush has priority over all transfers.
- Reset (any time, including mid-stall): out_valid=0, in_ready=1; Op, Op1, Op2, rd, br_funct3 = 0; is_branch=0; illegal=0; both entries invalid.
- After reset deassertion: the first accept is possible at the first rising edge.

Decomposition:
- Package alu_pkg: alu_op_e enum (the 9 codes above), RV opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH), and an issue_t struct {Op, Op1, Op2, rd, is_branch, br_funct3, illegal}.
- Sub-module alu_op_decode: purely combinational, maps instr, rs1_data, rs2_data to issue_t.
- Top level holds the skid-buffer control and registers.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=70, rs2=50, out_ready=1 → next cycle out_valid=1, Op=0000, Op1=70, Op2=50, rd=3, illegal=0.
- ADDI x5,x1,-1 (0xFFF08293), rs1=10 → Op=0000, Op2=-1 (0xFFFFFFFF), rd=5. SLLI x5,x1,4 → Op=0110, Op2=4.
- BGE x1,x2 (funct3 101), rs1=80, rs2=70 → Op=1000, Op1=80, Op2=70, is_branch=1, br_funct3=101, rd=0.
- Backpressure: out_ready=0, issue A then B back-to-back → A held stable on outputs, B captured in S, in_ready=0 the following cycle. out_ready=1 → A then B on consecutive cycles, in_ready returns to 1. No loss, no duplication.
- SRA x3,x1,x2 (funct7 0100000, funct3 101) → illegal=1, Op=0000, Op1=Op2=0, out_valid=1.
- Flush with M and S both full and in_valid=1 → next cycle out_valid=0, in_ready=1, none of the three entries ever appears. Repeat with rst asserted mid-stall instead → all outputs zero immediately (asynchronous).
